// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - fixed-priority arbiter sharing one single-port data BRAM between two requesters
module dmem_port_arbiter #(
    parameter int unsigned BRAM_SIZE    = 32'h6c00,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wd,
    output logic              a_ack,
    output logic [31:0]       a_rd,
    output logic              a_err,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wd,
    output logic              b_ack,
    output logic [31:0]       b_rd,
    output logic              b_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ACK} state_t;

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(BRAM_SIZE);
    localparam logic [7:0]        STARVE_MAX = 8'(STARVE_LIMIT);

    state_t            state;
    state_t            state_nxt;
    logic              owner_b;
    logic              op_we;
    logic [7:0]        starve_cnt;

    logic              grant_any;
    logic              grant_b;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wd;
    logic              sel_in_range;

    // B wins only when A is absent or B has lost STARVE_LIMIT arbitrations in a row
    always_comb begin
        grant_any    = a_req | b_req;
        grant_b      = b_req & (~a_req | (starve_cnt == STARVE_MAX));
        sel_we       = grant_b ? b_we   : a_we;
        sel_addr     = grant_b ? b_addr : a_addr;
        sel_wd       = grant_b ? b_wd   : a_wd;
        sel_in_range = sel_addr < ADDR_LIMIT;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = sel_in_range ? ISSUE : ACK;
                end
            end
            ISSUE:   state_nxt = op_we ? ACK : RDWAIT;
            RDWAIT:  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_b    <= 1'b0;
            op_we      <= 1'b0;
            starve_cnt <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
            a_ack      <= 1'b0;
            a_rd       <= '0;
            a_err      <= 1'b0;
            b_ack      <= 1'b0;
            b_rd       <= '0;
            b_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner_b <= grant_b;
                        op_we   <= sel_we;
                        if (grant_b) begin
                            starve_cnt <= '0;
                        end else if (b_req && starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + 8'd1;
                        end
                        if (sel_in_range) begin
                            mem_en   <= 1'b1;
                            mem_we   <= sel_we;
                            mem_addr <= sel_addr;
                            mem_wd   <= sel_wd;
                        end else if (grant_b) begin
                            b_ack <= 1'b1;
                            b_err <= 1'b1;
                            b_rd  <= '0;
                        end else begin
                            a_ack <= 1'b1;
                            a_err <= 1'b1;
                            a_rd  <= '0;
                        end
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    // write data is already in the array; read data lands next cycle
                    if (op_we) begin
                        if (owner_b) begin
                            b_ack <= 1'b1;
                            b_err <= 1'b0;
                        end else begin
                            a_ack <= 1'b1;
                            a_err <= 1'b0;
                        end
                    end
                end
                RDWAIT: begin
                    if (owner_b) begin
                        b_ack <= 1'b1;
                        b_rd  <= mem_rd;
                        b_err <= 1'b0;
                    end else begin
                        a_ack <= 1'b1;
                        a_rd  <= mem_rd;
                        a_err <= 1'b0;
                    end
                end
                ACK: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                end
                default: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

    localparam int          STARVE_LIMIT = 4;
    localparam logic [31:0] BRAM_SIZE    = 32'h6c00;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        a_req, a_we, a_ack, a_err;
    logic [31:0] a_addr, a_wd, a_rd;
    logic        b_req, b_we, b_ack, b_err;
    logic [31:0] b_addr, b_wd, b_rd;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    always #5 clock = ~clock;

    dmem_port_arbiter #(
        .BRAM_SIZE(32'h6c00),
        .ADDR_W(32),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wd(a_wd),
        .a_ack(a_ack), .a_rd(a_rd), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wd(b_wd),
        .b_ack(b_ack), .b_rd(b_rd), .b_err(b_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // BRAM with 1-cycle registered read
    bit [31:0] bram [0:32'h6bff];
    int        oob_cnt = 0;

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_addr >= BRAM_SIZE) oob_cnt <= oob_cnt + 1;
            else if (mem_we) bram[mem_addr[14:0]] <= mem_wd;
            else mem_rd <= bram[mem_addr[14:0]];
        end
    end

    int en_cnt = 0, a_ack_cnt = 0, b_ack_cnt = 0, dual_cnt = 0;
    int lost = 0, max_lost = 0;

    always @(negedge clock) begin
        if (mem_en) en_cnt <= en_cnt + 1;
        if (a_ack) a_ack_cnt <= a_ack_cnt + 1;
        if (b_ack) b_ack_cnt <= b_ack_cnt + 1;
        if (a_ack && b_ack) dual_cnt <= dual_cnt + 1;
        if (b_ack || !b_req) lost <= 0;
        else if (a_ack) lost <= lost + 1;
        if (lost > max_lost) max_lost <= lost;
    end

    // reference memory: what every completed write has left behind
    bit [31:0] ref_mem [bit [31:0]];
    int total = 0, bad = 0;

    function automatic logic [31:0] ref_rd(input logic [31:0] addr);
        if (ref_mem.exists(addr)) return ref_mem[addr];
        return 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // one request/ack handshake; lat/en_at counted in negedges after the sampling cycle
    task automatic op(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input bit hold, output int lat, output int en_at);
        logic [31:0] rd;
        logic        err;
        bit          exp_err;
        logic [31:0] exp_rd;
        @(negedge clock);
        if (p) begin b_we = we; b_addr = addr; b_wd = wd; b_req = 1'b1; end
        else   begin a_we = we; a_addr = addr; a_wd = wd; a_req = 1'b1; end
        lat = -1;
        en_at = -1;
        rd = '0;
        err = 1'b0;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(negedge clock);
            if (mem_en && en_at < 0) en_at = n;
            if (p ? b_ack : a_ack) begin
                lat = n;
                rd  = p ? b_rd : a_rd;
                err = p ? b_err : a_err;
            end
        end
        exp_err = addr >= BRAM_SIZE;
        exp_rd  = exp_err ? 32'd0 : ref_rd(addr);
        if (lat > 0 && we && !exp_err) ref_mem[addr] = wd;
        if (hold) begin
            @(posedge clock);
            #1;
        end
        if (p) b_req = 1'b0; else a_req = 1'b0;
        chk("ack_seen", lat > 0, 1);
        if (lat > 0) begin
            chk("err", err, exp_err);
            if (!we || exp_err) chk("rd", rd, exp_rd);
        end
    endtask

    task automatic rand_ops(input bit p, input int n);
        int          lat, en_at, r;
        logic [31:0] addr;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8) addr = $urandom_range(0, 15);
            else if (r == 8) addr = 32'h6bf0 + $urandom_range(0, 31);
            else addr = $urandom;
            op(p, 1'($urandom_range(0, 1)), addr, $urandom, 1'b0, lat, en_at);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int          lat, en_at, n_ack, last_cyc, e0, k0;
        logic [31:0] rd_val, ad;
        bit          w;
        bit          order [10];

        a_req = 0; a_we = 0; a_addr = 0; a_wd = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wd = 0;
        repeat (3) @(negedge clock);
        chk("reset_state", |{mem_en, mem_we, mem_addr, mem_wd, a_ack, a_rd, a_err, b_ack, b_rd, b_err}, 0);
        reset = 1'b1;

        // A write then read at addr 5
        op(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, lat, en_at);
        chk("t1_wr_lat", lat, 2);
        chk("t1_wr_en", en_at, 1);
        chk("t1_bram", bram[5], 32'hDEADBEEF);
        op(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, lat, en_at);
        chk("t1_rd_lat", lat, 3);
        chk("t1_rd_en", en_at, 1);
        chk("t1_rd_val", a_rd, 32'hDEADBEEF);

        // range boundary on B, then out-of-range on A
        op(1'b1, 1'b1, 32'h6bff, 32'h12345678, 1'b0, lat, en_at);
        chk("t3_wr_lat", lat, 2);
        op(1'b1, 1'b0, 32'h6bff, 32'd0, 1'b0, lat, en_at);
        chk("t3_rd_lat", lat, 3);
        op(1'b1, 1'b0, 32'h6c00, 32'd0, 1'b0, lat, en_at);
        chk("t3_oob_lat", lat, 1);
        chk("t3_oob_no_en", en_at < 0, 1);
        op(1'b1, 1'b0, 32'h6bff, 32'd0, 1'b0, lat, en_at);
        chk("t3_rd2_lat", lat, 3);
        chk("t3_rd2_val", b_rd, 32'h12345678);
        op(1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0, 1'b0, lat, en_at);
        chk("t3_a_oob_lat", lat, 1);

        // req held through the ACK cycle: one access, one ack
        @(negedge clock); #1;
        e0 = en_cnt;
        k0 = a_ack_cnt;
        op(1'b0, 1'b0, 32'd5, 32'd0, 1'b1, lat, en_at);
        repeat (6) @(negedge clock);
        #1;
        chk("t5_en_pulses", en_cnt - e0, 1);
        chk("t5_acks", a_ack_cnt - k0, 1);

        // async reset while an A read sits in RDWAIT
        op(1'b0, 1'b1, 32'd9, 32'hCAFEF00D, 1'b0, lat, en_at);
        @(negedge clock);
        a_we = 1'b0; a_addr = 32'd9; a_req = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("t4_rst_outs", |{mem_en, mem_we, mem_addr, mem_wd, a_ack, a_rd, a_err, b_ack, b_rd, b_err}, 0);
        k0 = a_ack_cnt;
        repeat (3) @(negedge clock);
        #1;
        chk("t4_no_ack", a_ack_cnt - k0, 0);
        @(negedge clock);
        reset = 1'b1;
        lat = -1;
        rd_val = '0;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(negedge clock);
            if (a_ack) begin lat = n; rd_val = a_rd; end
        end
        a_req = 1'b0;
        chk("t4_lat", lat, 3);
        chk("t4_rd", rd_val, 32'hCAFEF00D);

        // B alone: fixed latencies, never starving
        for (int i = 0; i < 10; i++) begin
            w  = 1'($urandom_range(0, 1));
            ad = $urandom_range(0, 32'h6bff);
            op(1'b1, w, ad, $urandom, 1'b0, lat, en_at);
            chk("t6_lat", lat, w ? 2 : 3);
            chk("t6_en", en_at, 1);
        end

        // both held, all reads: B takes every (LIMIT+1)th grant
        @(negedge clock);
        a_we = 1'b0; a_addr = 32'd1; b_we = 1'b0; b_addr = 32'd2;
        a_req = 1'b1; b_req = 1'b1;
        n_ack = 0;
        last_cyc = 0;
        for (int c = 1; c <= 100 && n_ack < 10; c++) begin
            @(negedge clock);
            if (a_ack || b_ack) begin
                order[n_ack] = b_ack;
                if (n_ack > 0) chk("t2_spacing", c - last_cyc, 4);
                last_cyc = c;
                n_ack++;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        chk("t2_count", n_ack, 10);
        for (int i = 0; i < 10; i++) begin
            chk("t2_grant_is_b", order[i], ((i + 1) % (STARVE_LIMIT + 1)) == 0);
        end

        // random contention
        repeat (2) @(negedge clock);
        fork
            rand_ops(1'b0, 30);
            rand_ops(1'b1, 30);
        join
        repeat (4) @(negedge clock);

        chk("dual_ack", dual_cnt, 0);
        chk("oob_access", oob_cnt, 0);
        chk("starve_bound", max_lost <= STARVE_LIMIT + 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
